// File: rtl/crc_frame_accum_if.sv
// Word-in / CRC-result handshake bundle for crc_frame_accum.
// slave is the accumulator's view; master is the producer/consumer side.
interface crc_frame_accum_if #(
  parameter int unsigned WORDWIDTH = 40,
  parameter int unsigned CRCWIDTH  = 8,
  parameter int unsigned CNTWIDTH  = 16
);
  logic [WORDWIDTH-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic                 din_sof;
  logic                 din_eof;
  logic                 din_dis;
  logic [CRCWIDTH-1:0]  crc_out;
  logic [CNTWIDTH-1:0]  crc_nwords;
  logic                 crc_valid;
  logic                 crc_ready;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output din, din_valid, din_sof, din_eof, din_dis, crc_ready,
    input  din_ready, crc_out, crc_nwords, crc_valid, frame_err, busy
  );

  modport slave (
    input  din, din_valid, din_sof, din_eof, din_dis, crc_ready,
    output din_ready, crc_out, crc_nwords, crc_valid, frame_err, busy
  );
endinterface

// File: rtl/crc_frame_accum.sv
// Frame CRC accumulator: one word per cycle through an unrolled MSB-first LFSR,
// framed by sof/eof, result held in an output register until the consumer takes it.
module crc_frame_accum #(
  parameter int unsigned         WORDWIDTH = 40,
  parameter int unsigned         CRCWIDTH  = 8,
  parameter logic [CRCWIDTH-1:0] POLY      = CRCWIDTH'(8'h2F),
  parameter logic [CRCWIDTH-1:0] INIT      = '0,
  parameter int unsigned         CNTWIDTH  = 16
) (
  input  logic             clk,
  input  logic             rstn,
  crc_frame_accum_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CRCWIDTH-1:0] crc_q, crc_d;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;
  logic [CRCWIDTH-1:0] out_crc_q, out_crc_d;
  logic [CNTWIDTH-1:0] out_cnt_q, out_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic                err_q, err_d;

  logic                 xfer;
  logic [WORDWIDTH-1:0] upd_word;
  logic [CRCWIDTH-1:0]  upd_crc;

  // Full-word LFSR advance, bit WORDWIDTH-1 shifted in first.
  function automatic logic [CRCWIDTH-1:0] crc_update(
    input logic [CRCWIDTH-1:0]  c_in,
    input logic [WORDWIDTH-1:0] w
  );
    logic [CRCWIDTH-1:0] c;
    logic                fb;
    c = c_in;
    for (int i = WORDWIDTH - 1; i >= 0; i--) begin
      fb = w[i] ^ c[CRCWIDTH-1];
      c  = {c[CRCWIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  // A stalled result blocks new words so it can never be overwritten.
  assign bus.din_ready  = ~out_valid_q | bus.crc_ready;
  assign xfer           = bus.din_valid & bus.din_ready;

  assign bus.crc_out    = out_crc_q;
  assign bus.crc_nwords = out_cnt_q;
  assign bus.crc_valid  = out_valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q == ACCUM);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      cnt_q       <= '0;
      out_crc_q   <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      out_crc_q   <= out_crc_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    out_crc_d   = out_crc_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q & ~bus.crc_ready;
    err_d       = 1'b0;

    // sof always reseeds, so the chain base is INIT whenever sof is set.
    upd_word = bus.din_dis ? '0 : bus.din;
    upd_crc  = crc_update(bus.din_sof ? INIT : crc_q, upd_word);

    if (xfer) begin
      if (bus.din_sof) begin
        err_d   = (state_q == ACCUM);
        crc_d   = upd_crc;
        cnt_d   = CNTWIDTH'(1);
        state_d = ACCUM;
      end else if (state_q == ACCUM) begin
        crc_d = upd_crc;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNTWIDTH'(1);
      end else begin
        err_d = 1'b1;
      end

      // eof only closes a frame that is open after this word.
      if (bus.din_eof && (state_d == ACCUM)) begin
        out_crc_d   = crc_d;
        out_cnt_d   = cnt_d;
        out_valid_d = 1'b1;
        state_d     = IDLE;
        crc_d       = INIT;
        cnt_d       = '0;
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_accum.sv
// Self-checking bench for crc_frame_accum: directed scenarios plus random
// back-to-back frames against a polynomial long-division reference.
module tb_crc_frame_accum;

  localparam int unsigned   WW   = 40;
  localparam int unsigned   CW   = 8;
  localparam int unsigned   NW   = 16;
  localparam logic [CW-1:0] POLY = 8'h2F;
  localparam logic [CW-1:0] INIT = 8'h00;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  crc_frame_accum_if #(.WORDWIDTH(WW), .CRCWIDTH(CW), .CNTWIDTH(NW)) bus ();

  crc_frame_accum #(
    .WORDWIDTH(WW), .CRCWIDTH(CW), .POLY(POLY), .INIT(INIT), .CNTWIDTH(NW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // CRC as remainder of (INIT*x^N + M(x)*x^CW) mod G, by plain long division.
  function automatic logic [CW-1:0] ref_crc(input logic [WW-1:0] words[$]);
    logic [CW:0] gen;
    logic [CW:0] r;
    bit          stream[$];
    gen = {1'b1, POLY};
    r   = '0;
    foreach (words[k])
      for (int b = WW - 1; b >= 0; b--) stream.push_back(words[k][b]);
    for (int b = 0; b < CW; b++) stream.push_back(1'b0);
    for (int b = 0; b < CW; b++) stream[b] = stream[b] ^ INIT[CW-1-b];
    foreach (stream[k]) begin
      r = {r[CW-1:0], stream[k]};
      if (r[CW]) r = r ^ gen;
    end
    return r[CW-1:0];
  endfunction

  function automatic logic [WW-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[WW-1:0];
  endfunction

  task automatic drive(input bit v, input logic [WW-1:0] d, input bit s, input bit e, input bit x);
    bus.din_valid = v;
    bus.din       = d;
    bus.din_sof   = s;
    bus.din_eof   = e;
    bus.din_dis   = x;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    idle();
    bus.crc_ready = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (bus.crc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.crc_valid); end
    checks++; if (bus.crc_out !== 8'h00) begin errors++; $display("FAIL reset_crc got=%h exp=00", bus.crc_out); end
    checks++; if (bus.crc_nwords !== 16'd0) begin errors++; $display("FAIL reset_nwords got=%0d exp=0", bus.crc_nwords); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.frame_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.din_ready); end
  endtask

  task automatic single_word(input string name, input logic [WW-1:0] d, input bit x, input logic [CW-1:0] exp);
    drive(1'b1, d, 1'b1, 1'b1, x);
    @(negedge clk);
    idle();
    checks++; if (bus.crc_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got=%b exp=1", name, bus.crc_valid); end
    checks++; if (bus.crc_out !== exp) begin errors++; $display("FAIL %s_crc got=%h exp=%h", name, bus.crc_out, exp); end
    checks++; if (bus.crc_nwords !== 16'd1) begin errors++; $display("FAIL %s_nwords got=%0d exp=1", name, bus.crc_nwords); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s_busy got=%b exp=0", name, bus.busy); end
    @(negedge clk);
    checks++; if (bus.crc_valid !== 1'b0) begin errors++; $display("FAIL %s_drop got=%b exp=0", name, bus.crc_valid); end
  endtask

  task automatic test_single();
    single_word("one", 40'h1, 1'b0, 8'h2F);
    single_word("two", 40'h2, 1'b0, 8'h5E);
    single_word("dis", 40'h2, 1'b1, 8'h00);
    single_word("rnd", 40'h12_3456_789A, 1'b0, ref_crc('{40'h12_3456_789A}));
  endtask

  task automatic test_stall();
    logic [WW-1:0] w[$];
    logic [CW-1:0] exp;
    for (int i = 0; i < 3; i++) w.push_back(rnd_word());
    exp = ref_crc(w);
    bus.crc_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, w[i], i == 0, i == 2, 1'b0);
      @(negedge clk);
      if (i == 0) begin
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy got=%b exp=1", bus.busy); end
      end
    end
    drive(1'b1, 40'h1, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      checks++; if (bus.crc_valid !== 1'b1 || bus.crc_out !== exp || bus.crc_nwords !== 16'd3) begin
        errors++; $display("FAIL stall_hold[%0d] got=%b/%h/%0d exp=1/%h/3", c, bus.crc_valid, bus.crc_out, bus.crc_nwords, exp);
      end
      checks++; if (bus.din_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got=%b exp=0", c, bus.din_ready); end
      @(negedge clk);
    end
    bus.crc_ready = 1'b1;
    #1;
    checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL stall_release got=%b exp=1", bus.din_ready); end
    @(negedge clk);
    idle();
    checks++; if (bus.crc_valid !== 1'b1 || bus.crc_out !== 8'h2F || bus.crc_nwords !== 16'd1) begin
      errors++; $display("FAIL stall_next got=%b/%h/%0d exp=1/2f/1", bus.crc_valid, bus.crc_out, bus.crc_nwords);
    end
    @(negedge clk);
    checks++; if (bus.crc_valid !== 1'b0) begin errors++; $display("FAIL stall_drop got=%b exp=0", bus.crc_valid); end
  endtask

  task automatic test_framing();
    logic [WW-1:0] w[$];
    logic [WW-1:0] d;
    drive(1'b1, rnd_word(), 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    idle();
    checks++; if (bus.frame_err !== 1'b1) begin errors++; $display("FAIL idle_nosof_err got=%b exp=1", bus.frame_err); end
    checks++; if (bus.crc_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_nosof_state got=%b/%b exp=0/0", bus.crc_valid, bus.busy); end
    @(negedge clk);
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL idle_nosof_pulse got=%b exp=0", bus.frame_err); end
    // abandoned frame A
    drive(1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL mid_err got=%b exp=0", bus.frame_err); end
    // frame B starts inside A; its middle word is disabled
    for (int i = 0; i < 3; i++) begin
      d = rnd_word();
      w.push_back((i == 1) ? '0 : d);
      drive(1'b1, d, i == 0, i == 2, i == 1);
      @(negedge clk);
      if (i == 0) begin
        checks++; if (bus.frame_err !== 1'b1 || bus.busy !== 1'b1 || bus.crc_valid !== 1'b0) begin
          errors++; $display("FAIL resof got=%b/%b/%b exp=1/1/0", bus.frame_err, bus.busy, bus.crc_valid);
        end
      end
    end
    idle();
    checks++; if (bus.crc_valid !== 1'b1 || bus.crc_out !== ref_crc(w) || bus.crc_nwords !== 16'd3 || bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL resof_result got=%b/%h/%0d/%b exp=1/%h/3/0", bus.crc_valid, bus.crc_out, bus.crc_nwords, bus.frame_err, ref_crc(w));
    end
    @(negedge clk);
    checks++; if (bus.crc_valid !== 1'b0) begin errors++; $display("FAIL resof_single got=%b exp=0", bus.crc_valid); end
  endtask

  task automatic test_reset_midframe();
    drive(1'b1, rnd_word(), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, rnd_word(), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    idle();
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.crc_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL arst_flags got=%b/%b/%b exp=0/0/0", bus.busy, bus.crc_valid, bus.frame_err);
    end
    checks++; if (bus.crc_out !== 8'h00 || bus.crc_nwords !== 16'd0) begin
      errors++; $display("FAIL arst_data got=%h/%0d exp=00/0", bus.crc_out, bus.crc_nwords);
    end
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 40'h5, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    idle();
    checks++; if (bus.crc_valid !== 1'b0 || bus.frame_err !== 1'b1) begin
      errors++; $display("FAIL arst_discard got=%b/%b exp=0/1", bus.crc_valid, bus.frame_err);
    end
    @(negedge clk);
    single_word("arst", 40'h1, 1'b0, 8'h2F);
  endtask

  task automatic test_back_to_back();
    logic [WW-1:0] fw[$];
    logic [WW-1:0] d;
    int            len;
    int            nframes;
    int            seen;
    bit            x;
    nframes = 40;
    seen    = 0;
    bus.crc_ready = 1'b1;
    for (int f = 0; f < nframes; f++) begin
      len = $urandom_range(1, 6);
      fw  = {};
      for (int i = 0; i < len; i++) begin
        d = rnd_word();
        x = ($urandom_range(0, 4) == 0);
        fw.push_back(x ? '0 : d);
        drive(1'b1, d, i == 0, i == len - 1, x);
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready f=%0d w=%0d got=%b exp=1", f, i, bus.din_ready); end
        @(negedge clk);
        if (bus.crc_valid === 1'b1) seen++;
        if (i == len - 1) begin
          checks++; if (bus.crc_valid !== 1'b1 || bus.crc_out !== ref_crc(fw) || bus.crc_nwords !== NW'(len)) begin
            errors++; $display("FAIL b2b_result f=%0d got=%b/%h/%0d exp=1/%h/%0d", f, bus.crc_valid, bus.crc_out, bus.crc_nwords, ref_crc(fw), len);
          end
        end else begin
          checks++; if (bus.crc_valid !== 1'b0) begin errors++; $display("FAIL b2b_spurious f=%0d w=%0d got=%b exp=0", f, i, bus.crc_valid); end
        end
        checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL b2b_err f=%0d w=%0d got=%b exp=0", f, i, bus.frame_err); end
      end
    end
    idle();
    @(negedge clk);
    checks++; if (bus.crc_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got=%b exp=0", bus.crc_valid); end
    checks++; if (seen != nframes) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", seen, nframes); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_framing();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
